// File: rtl/valid_ready_round_robin_arbiter_if.sv
// Handshake bundle between REQUESTERS upstream valid-ready channels and the single shared downstream channel.
// The master modport is the environment side, the slave modport is the arbiter side.
interface valid_ready_round_robin_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 4
);
  localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS*WIDTH-1:0] request_data;
  logic [REQUESTERS-1:0]       request_valid;
  logic [REQUESTERS-1:0]       request_ready;
  logic [WIDTH-1:0]            output_data;
  logic                        output_valid;
  logic                        output_ready;
  logic [INDEX_WIDTH-1:0]      grant_index;

  modport master (
    output request_data, request_valid, output_ready,
    input  request_ready, output_data, output_valid, grant_index
  );

  modport slave (
    input  request_data, request_valid, output_ready,
    output request_ready, output_data, output_valid, grant_index
  );
endinterface

// File: rtl/valid_ready_round_robin_arbiter.sv
// Zero-latency round-robin arbiter sharing one valid-ready output among REQUESTERS inputs; the grant is held while stalled.
// Define VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN to let a requester keep the grant for up to BURST_LENGTH transfers.
module valid_ready_round_robin_arbiter #(
  parameter int WIDTH        = 8,
  parameter int REQUESTERS   = 4,
  parameter int BURST_LENGTH = 4
) (
  input logic clock,
  input logic reset,
  valid_ready_round_robin_arbiter_if.slave bus
);
  localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned COUNT = REQUESTERS;

  if (REQUESTERS < 2 || BURST_LENGTH < 1) begin : g_bad_params
    $error("valid_ready_round_robin_arbiter: REQUESTERS must be >= 2 and BURST_LENGTH >= 1");
  end

  logic [INDEX_WIDTH-1:0] pointer;
  logic [INDEX_WIDTH-1:0] pointer_next;
  logic [INDEX_WIDTH-1:0] locked_index;
  logic                   locked;

  logic [INDEX_WIDTH-1:0] search_index;
  logic                   found;
  logic [INDEX_WIDTH-1:0] grant;
  logic [INDEX_WIDTH-1:0] grant_succ;
  logic                   has_grant;
  logic                   grant_valid;
  logic                   transfer;
  logic                   stall;
  logic [REQUESTERS-1:0]  ready;

  // First valid requester at or after pointer, wrapping at REQUESTERS.
  always_comb begin
    int unsigned idx;
    search_index = '0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < COUNT; k++) begin
      idx = int'(pointer) + k;
      if (idx >= COUNT) idx = idx - COUNT;
      if (!found && bus.request_valid[idx]) begin
        found        = 1'b1;
        search_index = idx[INDEX_WIDTH-1:0];
      end
    end
  end

  // Grant depends only on state and request_valid, never on output_ready.
  assign grant       = locked ? locked_index : search_index;
  assign has_grant   = !reset && (locked || found);
  assign grant_valid = has_grant && bus.request_valid[grant];
  assign grant_succ  = (int'(grant) == REQUESTERS - 1) ? '0 : grant + 1'b1;
  assign transfer    = grant_valid && bus.output_ready;
  assign stall       = grant_valid && !bus.output_ready;

  always_comb begin
    ready = '0;
    if (has_grant) ready[grant] = bus.output_ready;
  end

  assign bus.request_ready = ready;
  assign bus.output_valid  = grant_valid;
  assign bus.output_data   = has_grant ? bus.request_data[int'(grant)*WIDTH +: WIDTH] : '0;
  assign bus.grant_index   = has_grant ? grant : '0;

`ifdef VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN
  localparam int COUNT_WIDTH = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

  logic [COUNT_WIDTH-1:0] burst_count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [INDEX_WIDTH-1:0] pointer_succ;
  logic                   continuing;
  int unsigned            done;

  assign pointer_succ = (int'(pointer) == REQUESTERS - 1) ? '0 : pointer + 1'b1;

  // While a burst is open the pointer parks on its owner; a nonzero count means pointer is the owner.
  always_comb begin
    pointer_next = pointer;
    count_next   = burst_count;
    continuing   = (burst_count != '0) && (grant == pointer);
    done         = continuing ? int'(burst_count) + 1 : 1;
    if (transfer) begin
      if (done < BURST_LENGTH) begin
        pointer_next = grant;
        count_next   = COUNT_WIDTH'(done);
      end else begin
        pointer_next = grant_succ;
        count_next   = '0;
      end
    end else if (burst_count != '0 && !locked && !bus.request_valid[pointer]) begin
      pointer_next = pointer_succ;
      count_next   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) burst_count <= '0;
    else       burst_count <= count_next;
  end
`else
  always_comb begin
    pointer_next = pointer;
    if (transfer) pointer_next = grant_succ;
  end
`endif

  // Lock follows a stall; a transfer or a dropped valid releases it at the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pointer      <= '0;
      locked       <= 1'b0;
      locked_index <= '0;
    end else begin
      pointer <= pointer_next;
      locked  <= stall;
      if (stall) locked_index <= grant;
    end
  end
endmodule

// File: tb/tb_valid_ready_round_robin_arbiter.sv
// Self-checking bench for valid_ready_round_robin_arbiter (REQUESTERS=4, WIDTH=8): vector table, corner sequences
// and protocol-compliant random traffic against a queue-free behavioural model.
module tb_valid_ready_round_robin_arbiter;
  localparam int BL = 4;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  valid_ready_round_robin_arbiter_if #(.WIDTH(8), .REQUESTERS(4)) bus ();

  valid_ready_round_robin_arbiter #(.WIDTH(8), .REQUESTERS(4), .BURST_LENGTH(BL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  gi;
    logic [3:0]  rr;
  } vec_t;

  vec_t vecs [22];
  int   exp_seq [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d, input logic ordy);
    reset             = rst;
    bus.request_valid = v;
    bus.request_data  = d;
    bus.output_ready  = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b1, 4'h0, 32'h0, 1'b0);
    next_cycle();
    reset = 1'b0;
  endtask

  // Model state: highest-priority index, lock, and the currently open burst (owner, transfers so far).
  int       m_ptr, m_lidx, m_owner, m_run, g;
  bit       m_locked, has, e_ov, xfer;
  logic [3:0] pv;
  logic [7:0] pd [4];
  logic [7:0] e_od;
  logic [1:0] e_gi;
  logic [3:0] e_rr;
  logic       ordy;

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive(1'b1, 4'h0, 32'h0, 1'b0);

    vecs[0]  = '{1'b1, 4'hF, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0};
    vecs[1]  = '{1'b1, 4'hF, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h10, 2'd0, 4'h1};
    vecs[3]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h11, 2'd1, 4'h2};
    vecs[4]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h12, 2'd2, 4'h4};
    vecs[5]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h13, 2'd3, 4'h8};
    vecs[6]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h10, 2'd0, 4'h1};
    vecs[7]  = '{1'b0, 4'h4, 32'h00A50000, 1'b0, 1'b1, 8'hA5, 2'd2, 4'h0};
    vecs[8]  = '{1'b0, 4'h5, 32'h00A50077, 1'b0, 1'b1, 8'hA5, 2'd2, 4'h0};
    vecs[9]  = '{1'b0, 4'h5, 32'h00A50077, 1'b0, 1'b1, 8'hA5, 2'd2, 4'h0};
    vecs[10] = '{1'b0, 4'h5, 32'h00A50077, 1'b1, 1'b1, 8'hA5, 2'd2, 4'h4};
    vecs[11] = '{1'b0, 4'h5, 32'h00A50077, 1'b1, 1'b1, 8'h77, 2'd0, 4'h1};
    vecs[12] = '{1'b0, 4'h2, 32'h00002100, 1'b1, 1'b1, 8'h21, 2'd1, 4'h2};
    vecs[13] = '{1'b0, 4'hA, 32'h43002100, 1'b1, 1'b1, 8'h43, 2'd3, 4'h8};
    vecs[14] = '{1'b0, 4'hA, 32'h43002100, 1'b1, 1'b1, 8'h21, 2'd1, 4'h2};
    vecs[15] = '{1'b0, 4'h2, 32'h43002100, 1'b0, 1'b1, 8'h21, 2'd1, 4'h0};
    vecs[16] = '{1'b0, 4'h8, 32'h43002100, 1'b0, 1'b0, 8'h21, 2'd1, 4'h0};
    vecs[17] = '{1'b0, 4'h8, 32'h43002100, 1'b1, 1'b1, 8'h43, 2'd3, 4'h8};
    vecs[18] = '{1'b0, 4'h0, 32'h43002100, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0};
    vecs[19] = '{1'b0, 4'h4, 32'h00A50000, 1'b0, 1'b1, 8'hA5, 2'd2, 4'h0};
    vecs[20] = '{1'b1, 4'h4, 32'h00A50000, 1'b0, 1'b0, 8'h00, 2'd0, 4'h0};
    vecs[21] = '{1'b0, 4'h3, 32'h00002177, 1'b1, 1'b1, 8'h77, 2'd0, 4'h1};

    next_cycle();

`ifndef VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ordy);
      @(negedge clock);
      check($sformatf("row%0d valid", i), 32'(bus.output_valid), 32'(vecs[i].ov));
      check($sformatf("row%0d data", i), 32'(bus.output_data), 32'(vecs[i].od));
      check($sformatf("row%0d grant", i), 32'(bus.grant_index), 32'(vecs[i].gi));
      check($sformatf("row%0d ready", i), 32'(bus.request_ready), 32'(vecs[i].rr));
      next_cycle();
    end
`endif

    // output_ready must not disturb valid/data/grant within a cycle.
    reset_dut();
    drive(1'b0, 4'h6, 32'h00BBAA00, 1'b0);
    @(negedge clock);
    check("stall grant", 32'(bus.grant_index), 32'd1);
    check("stall ready", 32'(bus.request_ready), 32'h0);
    bus.output_ready = 1'b1;
    #1;
    check("ready-flip valid", 32'(bus.output_valid), 32'd1);
    check("ready-flip data", 32'(bus.output_data), 32'hAA);
    check("ready-flip ready", 32'(bus.request_ready), 32'h2);
    next_cycle();

`ifdef VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN
    reset_dut();
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
        drive(1'b0, 4'h6, 32'h00BBAA00, (c != 2));
        @(negedge clock);
        check($sformatf("burst c%0d grant", c), 32'(bus.grant_index), 32'(exp_seq[idx]));
        check($sformatf("burst c%0d valid", c), 32'(bus.output_valid), 32'd1);
        if (bus.output_ready) idx++;
        next_cycle();
      end
    end
`endif

    // Random protocol-compliant traffic: each requester holds valid and data until its transfer.
    reset_dut();
    m_ptr = 0; m_lidx = 0; m_owner = 0; m_run = 0; m_locked = 0;
    pv = '0;
    for (int i = 0; i < 4; i++) pd[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pd[i] = 8'($urandom_range(0, 255));
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive(1'b0, pv, {pd[3], pd[2], pd[1], pd[0]}, ordy);

      has = m_locked;
      g   = m_lidx;
      if (!m_locked) begin
        for (int k = 0; k < 4; k++) begin
          if (!has && pv[(m_ptr + k) % 4]) begin
            has = 1;
            g   = (m_ptr + k) % 4;
          end
        end
      end
      e_ov = has && pv[g];
      e_od = has ? pd[g] : 8'h00;
      e_gi = has ? 2'(g) : 2'd0;
      e_rr = (has && ordy) ? 4'(1 << g) : 4'h0;

      @(negedge clock);
      check($sformatf("rand c%0d valid/data", c), {23'h0, bus.output_valid, bus.output_data},
            {23'h0, e_ov, e_od});
      check($sformatf("rand c%0d grant/ready", c), {26'h0, bus.grant_index, bus.request_ready},
            {26'h0, e_gi, e_rr});

      xfer = e_ov && ordy;
      if (xfer) begin
`ifdef VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN
        if (m_run > 0 && g == m_owner) m_run++;
        else begin
          m_owner = g;
          m_run   = 1;
        end
        if (m_run == BL) begin
          m_ptr = (g + 1) % 4;
          m_run = 0;
        end else m_ptr = g;
`else
        m_ptr = (g + 1) % 4;
`endif
      end
`ifdef VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN
      else if (m_run > 0 && !m_locked && !pv[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        m_run = 0;
      end
`endif
      m_locked = e_ov && !ordy;
      if (m_locked) m_lidx = g;
      if (xfer) pv[g] = 1'b0;
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/valid_ready_round_robin_arbiter.md
# valid_ready_round_robin_arbiter

Shares one valid-ready output channel, typically the write side of a FIFO, between `REQUESTERS` valid-ready input channels. Arbitration is round-robin with zero added latency. The grant is locked while a transfer is stalled, so downstream sees stable data.

## Interface
- `WIDTH`, default 8: payload width per channel.
- `REQUESTERS`, default 4: number of input channels, minimum 2.
- `BURST_LENGTH`, default 4: maximum consecutive transfers per grant. Used only when the burst feature is compiled in. Minimum 1.
- Derived: `INDEX_WIDTH` = max(1, clog2(`REQUESTERS`)).

Ports:
- `clock`  in  1  Single clock, rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `request_data`  in  `REQUESTERS*WIDTH`  Channel i is bits [i*WIDTH +: WIDTH].
- `request_valid`  in  `REQUESTERS`  Per-channel valid.
- `request_ready`  out  `REQUESTERS`  Per-channel ready. One-hot or zero.
- `output_data`  out  `WIDTH`  Data of the granted channel. Zero when no grant.
- `output_valid`  out  1  Valid of the granted channel.
- `output_ready`  in  1  Downstream ready.
- `grant_index`  out  `INDEX_WIDTH`  Index of the granted channel. Zero when no grant.

## Operation
- **State registers:**
  - `pointer`, INDEX_WIDTH bits: the highest-priority index.
  - `locked`, 1 bit.
  - `locked_index`.
  - `burst_count`, only with the macro.
- **Selection when not locked:** the first i with `request_valid[i]` = 1, searching `pointer`, `pointer+1`, … modulo `REQUESTERS`. Wrap-around applies for non-power-of-2 `REQUESTERS` (index `REQUESTERS-1` wraps to 0).
- **Selection when locked:** the grant is `locked_index`, regardless of the other requests.
- **Datapath:**
  - `output_valid` = `request_valid[grant]`.
  - `output_data` = `request_data[grant]`.
  - `request_ready[grant]` = `output_ready`.
  - All other `request_ready` bits are 0.
- **A transfer** is `output_valid` && `output_ready` at a rising edge.
- **Lock:** set at an edge where `output_valid` && !`output_ready`, capturing the grant. Cleared on a transfer.
  - If the locked requester drops valid (a protocol violation), the lock clears at that edge and arbitration resumes.
- **Pointer update on a transfer from index g:** `pointer` becomes (g+1) mod `REQUESTERS`. The pointer is unchanged otherwise.
- **Idle:** no request valid gives `output_valid` = 0, all ready bits 0, `grant_index` = 0, and state unchanged.
- **During reset:**
  - `output_valid`, `request_ready`, `output_data` and `grant_index` are forced to 0.
  - At the edge: `pointer` = 0, `locked` = 0, `burst_count` = 0.
  - A reset mid-lock discards the lock. The stalled transfer does not occur.

## Timing
- Zero latency: the valid/data and ready paths are combinational. No bubble cycles, so throughput is one transfer per clock when `output_ready` = 1.
- Grant changes only take effect at a rising edge after a transfer, a lock release or a reset.
- No combinational path exists from `output_ready` to `output_valid` or `output_data`.
- Stall: while locked, `output_data` and `grant_index` are held stable until the transfer, provided the requester obeys valid-ready.

## Configuration
- Macro: `VALID_READY_ROUND_ROBIN_ARBITER_BURST_EN`.
- **Defined:**
  - The grant stays on the same requester after a transfer if it is still valid and `burst_count`+1 < `BURST_LENGTH`. In that case `pointer` is not advanced and `burst_count` increments.
  - When `BURST_LENGTH` transfers are reached, or the requester drops valid, `pointer` advances to g+1 and `burst_count` returns to 0.
  - A stall does not change `burst_count`.
- **Undefined:**
  - The pointer advances after every transfer.
  - `BURST_LENGTH` is ignored and no burst counter is built.

## Test plan
All scenarios use `REQUESTERS`=4 and `WIDTH`=8.
- **Reset:** hold `reset` with all `request_valid` = 4'b1111 -> `output_valid` = 0, `request_ready` = 0, `grant_index` = 0. After release, the first grant is 0.
- **Fairness, macro undefined:** all four valid, data 0x10+i, `output_ready` = 1 constantly -> `output_data` sequence 0x10, 0x11, 0x12, 0x13, 0x10…, one per cycle.
- **Stall lock:** only requester 2 valid with 0xA5, `output_ready` = 0 for 3 cycles, and requester 0 asserts in cycle 2 -> `grant_index` = 2 and 0xA5 stable for 3 cycles. When `output_ready` = 1, 0xA5 transfers, then the next cycle grants 0.
- **Rotation from pointer:** set pointer = 2 by transferring from requester 1, then assert requesters 1 and 3 -> grant 3, then 1.
- **Protocol-violation release:** lock on requester 1, then drop `request_valid[1]` with requester 3 valid -> at the next edge the grant moves to 3 and no transfer from 1 is counted.
- **Burst, macro defined, `BURST_LENGTH`=4:** requesters 1 and 2 continuously valid, `output_ready` = 1 -> transfers 1,1,1,1,2,2,2,2,1…. One cycle of `output_ready` = 0 mid-burst does not shorten the burst.
